// File: rtl/res_st_issue.sv
// res_st_issue: reservation station between the front end's write port and an
// execution unit. Holds micro-ops until both sources are ready, snoops the CDB
// to wake waiting operands, and issues the lowest-index ready entry through a
// one-deep valid/ready issue register.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous; drops every entry and the issue register
//   wr_en/wr_addr/wr_data   front-end write into a free slot
//   cdb_valid/cdb_tag/cdb_data   common data bus broadcast
//   issue_valid/issue_ready/issue_data   issue handshake to the execution unit
//   free_addr, full combinational slot status from current valid bits
//   count           registered number of valid slots
//   err_overwrite   sticky: a write targeted an occupied slot

package res_st_pkg;

  localparam int unsigned PHY_RF_ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned ROB_ADDR_WIDTH    = 5;
  localparam int unsigned UOP_WIDTH         = 8;

  typedef struct packed {
    logic [UOP_WIDTH-1:0]         uop;
    logic [ROB_ADDR_WIDTH-1:0]    rob_addr;
    logic [PHY_RF_ADDR_WIDTH-1:0] rd_tag;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs1_tag;
    logic                         rs1_ready;
    logic [DATA_WIDTH-1:0]        rs1_data;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs2_tag;
    logic                         rs2_ready;
    logic [DATA_WIDTH-1:0]        rs2_data;
  } res_st_cell_t;

endpackage

module res_st_issue #(
  parameter int unsigned RES_ST_DEPTH = 16,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       flush,
  input  logic                                       wr_en,
  input  logic [$clog2(RES_ST_DEPTH)-1:0]            wr_addr,
  input  res_st_pkg::res_st_cell_t                   wr_data,
  input  logic                                       cdb_valid,
  input  logic [res_st_pkg::PHY_RF_ADDR_WIDTH-1:0]   cdb_tag,
  input  logic [DATA_WIDTH-1:0]                      cdb_data,
  output logic                                       issue_valid,
  input  logic                                       issue_ready,
  output res_st_pkg::res_st_cell_t                   issue_data,
  output logic [$clog2(RES_ST_DEPTH)-1:0]            free_addr,
  output logic                                       full,
  output logic [$clog2(RES_ST_DEPTH):0]              count,
  output logic                                       err_overwrite
);

  localparam int unsigned ADDR_W  = $clog2(RES_ST_DEPTH);
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned CELL_DW = res_st_pkg::DATA_WIDTH;

  typedef logic [ADDR_W-1:0] res_st_addr_t;

  logic [RES_ST_DEPTH-1:0]  valid_q;
  logic [RES_ST_DEPTH-1:0]  valid_d;
  res_st_pkg::res_st_cell_t entry_q [RES_ST_DEPTH];
  res_st_pkg::res_st_cell_t entry_d [RES_ST_DEPTH];
  res_st_pkg::res_st_cell_t wr_cell;

  logic [CELL_DW-1:0] cdb_value;
  logic               wr_ok;
  logic               wr_err;
  logic               cand_found;
  res_st_addr_t       cand_idx;
  logic               issue_load;
  logic               issue_take;

  assign cdb_value = CELL_DW'(cdb_data);

  // Incoming entry with same-cycle CDB bypass applied to waiting sources.
  always_comb begin
    wr_cell = wr_data;
    if (cdb_valid && !wr_data.rs1_ready && (wr_data.rs1_tag == cdb_tag)) begin
      wr_cell.rs1_ready = 1'b1;
      wr_cell.rs1_data  = cdb_value;
    end
    if (cdb_valid && !wr_data.rs2_ready && (wr_data.rs2_tag == cdb_tag)) begin
      wr_cell.rs2_ready = 1'b1;
      wr_cell.rs2_data  = cdb_value;
    end
  end

  // Lowest-index valid slot with both sources ready.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
      if (!cand_found && valid_q[i] && entry_q[i].rs1_ready && entry_q[i].rs2_ready) begin
        cand_found = 1'b1;
        cand_idx   = ADDR_W'(i);
      end
    end
  end

  // Lowest-index free slot; reads 0 when the station is full.
  always_comb begin
    free_addr = '0;
    for (int i = int'(RES_ST_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_addr = ADDR_W'(i);
      end
    end
  end

  assign full = &valid_q;

  // A slot handed to the issue register is still occupied this cycle, so a
  // write to it is rejected like any other overwrite.
  assign wr_ok      = wr_en && !valid_q[wr_addr];
  assign wr_err     = wr_en &&  valid_q[wr_addr];
  assign issue_load = !issue_valid || issue_ready;
  assign issue_take = issue_load && cand_found;

  // Next valid vector; flush overrides everything.
  always_comb begin
    valid_d = valid_q;
    if (issue_take) begin
      valid_d[cand_idx] = 1'b0;
    end
    if (wr_ok) begin
      valid_d[wr_addr] = 1'b1;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Next payloads: CDB wakeup on stored entries, then writes into free slots.
  always_comb begin
    for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
      entry_d[i] = entry_q[i];
      if (cdb_valid && !entry_q[i].rs1_ready && (entry_q[i].rs1_tag == cdb_tag)) begin
        entry_d[i].rs1_ready = 1'b1;
        entry_d[i].rs1_data  = cdb_value;
      end
      if (cdb_valid && !entry_q[i].rs2_ready && (entry_q[i].rs2_tag == cdb_tag)) begin
        entry_d[i].rs2_ready = 1'b1;
        entry_d[i].rs2_data  = cdb_value;
      end
      if (wr_ok && (wr_addr == ADDR_W'(i))) begin
        entry_d[i] = wr_cell;
      end
    end
  end

  function automatic logic [CNT_W-1:0] popcount(input logic [RES_ST_DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Control state: slot valid bits, occupancy, issue register, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      count         <= '0;
      issue_valid   <= 1'b0;
      issue_data    <= '0;
      err_overwrite <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count   <= popcount(valid_d);
      if (flush) begin
        issue_valid <= 1'b0;
      end else if (issue_load) begin
        issue_valid <= cand_found;
        if (cand_found) begin
          issue_data <= entry_q[cand_idx];
        end
      end
      if (wr_err && !flush) begin
        err_overwrite <= 1'b1;
      end
    end
  end

  // Payload storage; qualified by valid_q, so no reset is needed.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_res_st_issue.sv
// Directed testbench for res_st_issue: one task per scenario, inline checks.
module tb_res_st_issue;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic                     wr_en;
  logic [3:0]               wr_addr;
  res_st_pkg::res_st_cell_t wr_data;
  logic                     cdb_valid;
  logic [5:0]               cdb_tag;
  logic [31:0]              cdb_data;
  logic                     issue_valid;
  logic                     issue_ready;
  res_st_pkg::res_st_cell_t issue_data;
  logic [3:0]               free_addr;
  logic                     full;
  logic [4:0]               count;
  logic                     err_overwrite;

  int checks;
  int failures;

  res_st_issue #(.RES_ST_DEPTH(16), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_data    (issue_data),
    .free_addr     (free_addr),
    .full          (full),
    .count         (count),
    .err_overwrite (err_overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_st_pkg::res_st_cell_t mk(input logic [4:0] rob,
                                                  input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                                                  input logic [5:0] t2, input logic r2, input logic [31:0] d2);
    res_st_pkg::res_st_cell_t c;
    c           = '0;
    c.uop       = 8'(rob) + 8'h40;
    c.rob_addr  = rob;
    c.rd_tag    = 6'h20 ^ 6'(rob);
    c.rs1_tag   = t1;
    c.rs1_ready = r1;
    c.rs1_data  = d1;
    c.rs2_tag   = t2;
    c.rs2_ready = r2;
    c.rs2_data  = d2;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_data    = '0;
    issue_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0b exp=0", issue_valid); end
    checks++; if (issue_data !== '0) begin failures++; $display("FAIL reset_issue_data got=%h exp=0", issue_data); end
    checks++; if (free_addr !== 4'd0) begin failures++; $display("FAIL reset_free_addr got=%0d exp=0", free_addr); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (err_overwrite !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_overwrite); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_issue();
    do_reset();
    issue_ready = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = mk(5'd5, 6'd1, 1'b1, 32'h1111, 6'd2, 1'b1, 32'h2222);
    step();
    wr_en = 1'b0;
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count_after_write got=%0d exp=1", count); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL single_not_yet_issued got=%0b exp=0", issue_valid); end
    step();
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL single_issue_valid got=%0b exp=1", issue_valid); end
    checks++; if (issue_data.rob_addr !== 5'd5) begin failures++; $display("FAIL single_rob got=%0d exp=5", issue_data.rob_addr); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", count); end
    checks++; if (free_addr !== 4'd0) begin failures++; $display("FAIL single_free_addr got=%0d exp=0", free_addr); end
    step();
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", issue_valid); end
  endtask

  task automatic test_wakeup();
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = mk(5'(i), 6'd7, 1'b0, 32'h0, 6'd0, 1'b1, 32'h20 + 32'(i));
      step();
    end
    wr_en = 1'b0;
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL wakeup_count_wait got=%0d exp=4", count); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wakeup_premature got=%0b exp=0", issue_valid); end
    cdb_valid = 1'b1;
    cdb_tag   = 6'd7;
    cdb_data  = 32'h55;
    step();
    cdb_valid = 1'b0;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wakeup_latency got=%0b exp=0", issue_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_data.rob_addr !== 5'(i) || issue_data.rs1_data !== 32'h55 ||
          issue_data.rs1_ready !== 1'b1 || issue_data.rs2_data !== 32'h20 + 32'(i)) begin
        failures++;
        $display("FAIL wakeup_issue_%0d got v=%0b rob=%0d rs1=%h rs2=%h exp v=1 rob=%0d rs1=55 rs2=%h",
                 i, issue_valid, issue_data.rob_addr, issue_data.rs1_data, issue_data.rs2_data, i, 32'h20 + 32'(i));
      end
    end
    step();
    checks++; if (issue_valid !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL wakeup_drained got v=%0b cnt=%0d exp v=0 cnt=0", issue_valid, count); end
  endtask

  task automatic test_full();
    do_reset();
    issue_ready = 1'b0;
    // slot 0 moves into the issue register, slots 1..15 fill, then slot 0 is reused
    for (int k = 0; k < 17; k++) begin
      if (k == 16) begin
        checks++; if (free_addr !== 4'd0) begin failures++; $display("FAIL full_free_before_last got=%0d exp=0", free_addr); end
      end
      wr_en   = 1'b1;
      wr_addr = (k == 16) ? 4'd0 : 4'(k);
      wr_data = mk(5'(k), 6'd1, 1'b1, 32'h100 + 32'(k), 6'd2, 1'b1, 32'h0);
      step();
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", full); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", count); end
    checks++; if (issue_valid !== 1'b1 || issue_data.rob_addr !== 5'd0) begin failures++; $display("FAIL full_head got v=%0b rob=%0d exp v=1 rob=0", issue_valid, issue_data.rob_addr); end
    step();
    step();
    checks++; if (issue_data.rob_addr !== 5'd0 || issue_data.rs1_data !== 32'h100 || count !== 5'd16) begin
      failures++; $display("FAIL full_stall_stable got rob=%0d rs1=%h cnt=%0d exp rob=0 rs1=100 cnt=16", issue_data.rob_addr, issue_data.rs1_data, count);
    end
    issue_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (issue_valid !== 1'b1 || issue_data.rob_addr !== ((i == 0) ? 5'd16 : 5'(i))) begin
        failures++;
        $display("FAIL full_issue_%0d got v=%0b rob=%0d exp v=1 rob=%0d", i, issue_valid, issue_data.rob_addr, (i == 0) ? 16 : i);
      end
      if (i == 0) begin
        checks++; if (full !== 1'b0 || count !== 5'd15) begin failures++; $display("FAIL full_release got full=%0b cnt=%0d exp full=0 cnt=15", full, count); end
      end
    end
    step();
    checks++; if (issue_valid !== 1'b0 || count !== 5'd0 || full !== 1'b0) begin failures++; $display("FAIL full_empty got v=%0b cnt=%0d full=%0b exp 0/0/0", issue_valid, count, full); end
  endtask

  task automatic test_bypass();
    do_reset();
    issue_ready = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 4'd2;
    wr_data   = mk(5'd12, 6'd4, 1'b1, 32'h11, 6'd9, 1'b0, 32'h0);
    cdb_valid = 1'b1;
    cdb_tag   = 6'd9;
    cdb_data  = 32'hA;
    step();
    wr_en     = 1'b0;
    cdb_valid = 1'b0;
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL bypass_count got=%0d exp=1", count); end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_data.rob_addr !== 5'd12 || issue_data.rs2_data !== 32'hA ||
                  issue_data.rs2_ready !== 1'b1 || issue_data.rs1_data !== 32'h11) begin
      failures++; $display("FAIL bypass_issue got v=%0b rob=%0d rs2=%h rdy=%0b rs1=%h exp v=1 rob=12 rs2=a rdy=1 rs1=11",
                           issue_valid, issue_data.rob_addr, issue_data.rs2_data, issue_data.rs2_ready, issue_data.rs1_data);
    end
    // tag mismatch must leave the operand waiting
    wr_en     = 1'b1;
    wr_addr   = 4'd5;
    wr_data   = mk(5'd13, 6'd4, 1'b1, 32'h11, 6'd9, 1'b0, 32'h0);
    cdb_valid = 1'b1;
    cdb_tag   = 6'd8;
    cdb_data  = 32'hB;
    step();
    wr_en     = 1'b0;
    cdb_valid = 1'b0;
    step();
    step();
    checks++; if (issue_valid !== 1'b0 || count !== 5'd1) begin failures++; $display("FAIL bypass_mismatch got v=%0b cnt=%0d exp v=0 cnt=1", issue_valid, count); end
  endtask

  task automatic test_overwrite();
    do_reset();
    issue_ready = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = mk(5'd3, 6'd3, 1'b0, 32'h0, 6'd1, 1'b1, 32'h77);
    step();
    wr_data = mk(5'd9, 6'd1, 1'b1, 32'h99, 6'd1, 1'b1, 32'h99);
    step();
    wr_en = 1'b0;
    checks++; if (err_overwrite !== 1'b1) begin failures++; $display("FAIL overwrite_err got=%0b exp=1", err_overwrite); end
    checks++; if (count !== 5'd1 || issue_valid !== 1'b0) begin failures++; $display("FAIL overwrite_count got cnt=%0d v=%0b exp cnt=1 v=0", count, issue_valid); end
    issue_ready = 1'b1;
    cdb_valid   = 1'b1;
    cdb_tag     = 6'd3;
    cdb_data    = 32'h33;
    step();
    cdb_valid = 1'b0;
    step();
    checks++; if (issue_valid !== 1'b1 || issue_data.rob_addr !== 5'd3 || issue_data.rs1_data !== 32'h33 || issue_data.rs2_data !== 32'h77) begin
      failures++; $display("FAIL overwrite_original got v=%0b rob=%0d rs1=%h rs2=%h exp v=1 rob=3 rs1=33 rs2=77",
                           issue_valid, issue_data.rob_addr, issue_data.rs1_data, issue_data.rs2_data);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (err_overwrite !== 1'b1) begin failures++; $display("FAIL overwrite_sticky_flush got=%0b exp=1", err_overwrite); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_ready = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = mk(5'd1, 6'd1, 1'b1, 32'h1, 6'd1, 1'b1, 32'h1);
    step();
    // slot 0 is being moved out this cycle: the write must be dropped
    wr_data = mk(5'd2, 6'd1, 1'b1, 32'h2, 6'd1, 1'b1, 32'h2);
    step();
    wr_en = 1'b0;
    checks++; if (issue_valid !== 1'b1 || issue_data.rob_addr !== 5'd1) begin failures++; $display("FAIL b2b_issue got v=%0b rob=%0d exp v=1 rob=1", issue_valid, issue_data.rob_addr); end
    checks++; if (err_overwrite !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL b2b_dropped got err=%0b cnt=%0d exp err=1 cnt=0", err_overwrite, count); end
    step();
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_ghost got=%0b exp=0", issue_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = mk(5'(20 + i), 6'd1, 1'b1, 32'h5, 6'd1, 1'b1, 32'h6);
      step();
    end
    checks++; if (count !== 5'd3 || issue_valid !== 1'b1 || free_addr !== 4'd0) begin
      failures++; $display("FAIL flush_setup got cnt=%0d v=%0b free=%0d exp cnt=3 v=1 free=0", count, issue_valid, free_addr);
    end
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd4;
    wr_data = mk(5'd30, 6'd1, 1'b1, 32'h5, 6'd1, 1'b1, 32'h6);
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    checks++; if (count !== 5'd0 || issue_valid !== 1'b0 || full !== 1'b0 || free_addr !== 4'd0) begin
      failures++; $display("FAIL flush_clear got cnt=%0d v=%0b full=%0b free=%0d exp 0/0/0/0", count, issue_valid, full, free_addr);
    end
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_no_issue_%0d got=%0b exp=0", i, issue_valid); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_ready = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = mk(5'd7, 6'd1, 1'b1, 32'h1, 6'd1, 1'b1, 32'h1);
    step();
    wr_addr = 4'd1;
    step();
    wr_addr = 4'd1;
    step();
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || issue_valid !== 1'b0 || err_overwrite !== 1'b0) begin
      failures++; $display("FAIL async_reset got cnt=%0d v=%0b err=%0b exp 0/0/0", count, issue_valid, err_overwrite);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_single_issue();
    test_wakeup();
    test_full();
    test_bypass();
    test_overwrite();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
